proj_sketch_drain: RTL and testbench
====================================

# proj_sketch_drain

Read-out block on the output side of the bottom-k sorter. On a snapshot request it captures the sorter's parallel smallest-index vector and fill count. It then streams the captured indices, smallest signature first, as one index per beat over a valid/ready interface toward the host/export path. This frees the sorter to keep accepting new signatures while the previous sketch drains.

## Interface
Parameters:
- INDICES_COUNT, default proj_pkg::HASHER_EXTENDER_INDICES_COUNT, number of sketch slots (≥2).
- INDICE_LEN, default 8, width of one index.
- CNT_W, default $clog2(INDICES_COUNT+1), width of the fill count.

Ports:
- in_clk  input  1  sole clock, rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_smallest_idx  input  [INDICES_COUNT-1:0][INDICE_LEN-1:0]  sorter output; slot 0 holds the smallest signature.
- in_fill_count  input  CNT_W  number of valid slots (0..INDICES_COUNT); values above INDICES_COUNT are clamped.
- in_snap  input  1  single-cycle snapshot/start request.
- out_idx  output  INDICE_LEN  current beat data.
- out_valid  output  1  beat valid.
- in_ready  input  1  downstream ready.
- out_last  output  1  marks the final beat of a stream.
- out_busy  output  1  a stream is in progress.
- out_empty  output  1  one-cycle pulse when a snapshot finds fill count 0.
- out_snap_dropped  output  1  one-cycle pulse when in_snap is ignored because the block is busy.

## Operation
- FSM states:
  - IDLE: out_valid=0, out_busy=0.
  - SEND: out_valid=1, out_busy=1.
  - CSUM: only when the checksum feature is compiled in; see Configuration.
- IDLE + in_snap with clamped count N>0:
  - Register in_smallest_idx into the shadow array and N into cnt_q.
  - Clear the pointer ptr to 0 and the checksum to 0.
  - Go to SEND.
- IDLE + in_snap with N=0: pulse out_empty for one cycle; stay in IDLE.
- SEND:
  - out_idx = shadow[ptr].
  - out_last = (ptr == cnt_q-1), except when the checksum feature is enabled (see Configuration).
  - On handshake (out_valid && in_ready): XOR out_idx into the checksum and advance ptr.
  - On the final data beat, go to IDLE, or to CSUM when the checksum feature is enabled.
- in_snap seen in any state other than IDLE, including the final-handshake cycle: ignored; out_snap_dropped pulses the next cycle.
- Changes on in_smallest_idx or in_fill_count after capture have no effect on the stream in flight.
- Output stability: while out_valid=1 and in_ready=0, out_idx and out_last stay constant.
- Reset (asynchronous, any state, including mid-stream):
  - State goes to IDLE; ptr, cnt_q and checksum go to 0.
  - All outputs go to 0: out_idx=0, out_valid=0, out_last=0, out_busy=0, out_empty=0, out_snap_dropped=0.
  - A partial stream is abandoned with no trailing beat.

## Timing
- in_snap is sampled at a rising edge. out_valid rises on that same edge, so the first beat is visible one cycle after in_snap.
- Throughput: one beat per cycle while in_ready=1. A stream of N indices takes N cycles, or N+1 with the checksum.
- After the last handshake, out_valid=0 and out_busy=0 the following cycle. The earliest accepted next in_snap is that IDLE cycle, so back-to-back streams have a minimum gap of 1 cycle.
- out_empty and out_snap_dropped are registered, asserted for exactly 1 cycle, one cycle after the triggering in_snap.
- All outputs are registered; there is no combinational path from in_ready to out_valid.

## Configuration
- PROJ_DRAIN_CSUM_EN defined:
  - After the N data beats, one extra beat is sent in state CSUM.
  - That beat carries out_idx = XOR of all N streamed indices, with out_last=1.
  - out_last is 0 on every data beat.
  - State returns to IDLE on the CSUM handshake.
- PROJ_DRAIN_CSUM_EN undefined:
  - CSUM state and checksum register are absent.
  - out_last=1 on data beat N-1.

## Test plan
- Reset, fill=4, slots {0x05,0x11,0x22,0x3A,...}, in_snap, in_ready=1: beats 0x05,0x11,0x22,0x3A on consecutive cycles, out_last on 0x3A. With CSUM_EN: a fifth beat 0x0C with out_last, and 0x3A has out_last=0.
- Same stream with in_ready toggling 1,0,0,1,...: each beat is held stable while ready is low, no beat is lost or duplicated, and the total count is 4.
- fill=0 plus in_snap: out_empty pulses once, out_valid stays 0. fill=INDICES_COUNT+3: exactly INDICES_COUNT beats.
- in_snap in cycle 2 of an active stream, and again on the final-handshake cycle: out_snap_dropped pulses each time, the stream is unaffected, and no new stream starts.
- Capture, then change in_smallest_idx to all 0xFF mid-stream: the streamed data still matches the captured values.
- Assert in_rst during beat 2 of 4: out_valid/out_busy/out_last drop to 0 immediately (asynchronous). After release, a new in_snap streams from slot 0.

Source files
------------

// File: rtl/proj_sketch_drain.sv
// proj_sketch_drain: snapshot read-out of the bottom-k sorter, one index per beat.
// Optional trailing XOR checksum beat when PROJ_DRAIN_CSUM_EN is defined.

package proj_pkg;
    localparam int HASHER_EXTENDER_INDICES_COUNT = 8;
endpackage

module proj_sketch_drain #(
    parameter int INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN    = 8,
    parameter int CNT_W         = $clog2(INDICES_COUNT + 1)
) (
    input  logic                                     in_clk,
    input  logic                                     in_rst,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
    input  logic [CNT_W-1:0]                         in_fill_count,
    input  logic                                     in_snap,
    output logic [INDICE_LEN-1:0]                    out_idx,
    output logic                                     out_valid,
    input  logic                                     in_ready,
    output logic                                     out_last,
    output logic                                     out_busy,
    output logic                                     out_empty,
    output logic                                     out_snap_dropped
);

    localparam int PTR_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(INDICES_COUNT);

`ifdef PROJ_DRAIN_CSUM_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND
    } state_t;
`endif

    state_t                                   state_q;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] shadow_q;
    logic [PTR_W-1:0]                         ptr_q;
    logic [PTR_W-1:0]                         ptr_nxt;
    logic [CNT_W-1:0]                         cnt_q;
    logic [CNT_W-1:0]                         fill_n;
    logic                                     hs;
    logic                                     at_end;
    logic                                     nxt_last;
`ifdef PROJ_DRAIN_CSUM_EN
    logic [INDICE_LEN-1:0]                    csum_q;
    logic [INDICE_LEN-1:0]                    csum_nxt;
`endif

    // Clamp the fill count, compute handshake and end-of-data flags.
    always_comb begin
        fill_n   = (in_fill_count > MAX_CNT) ? MAX_CNT : in_fill_count;
        hs       = out_valid & in_ready;
        ptr_nxt  = ptr_q + PTR_W'(1);
        at_end   = (CNT_W'(ptr_q) == (cnt_q - CNT_W'(1)));
        nxt_last = (CNT_W'(ptr_nxt) == (cnt_q - CNT_W'(1)));
`ifdef PROJ_DRAIN_CSUM_EN
        csum_nxt = csum_q ^ out_idx;
`endif
    end

    // Capture-and-stream FSM; every output is registered here.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q          <= S_IDLE;
            shadow_q         <= '0;
            ptr_q            <= '0;
            cnt_q            <= '0;
            out_idx          <= '0;
            out_valid        <= 1'b0;
            out_last         <= 1'b0;
            out_busy         <= 1'b0;
            out_empty        <= 1'b0;
            out_snap_dropped <= 1'b0;
`ifdef PROJ_DRAIN_CSUM_EN
            csum_q           <= '0;
`endif
        end else begin
            out_empty        <= 1'b0;
            out_snap_dropped <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_snap) begin
                        if (fill_n == '0) begin
                            out_empty <= 1'b1;
                        end else begin
                            shadow_q  <= in_smallest_idx;
                            cnt_q     <= fill_n;
                            ptr_q     <= '0;
                            out_idx   <= in_smallest_idx[0];
                            out_valid <= 1'b1;
                            out_busy  <= 1'b1;
                            state_q   <= S_SEND;
`ifdef PROJ_DRAIN_CSUM_EN
                            csum_q    <= '0;
                            out_last  <= 1'b0;
`else
                            out_last  <= (fill_n == CNT_W'(1));
`endif
                        end
                    end
                end
                S_SEND: begin
                    if (in_snap) begin
                        out_snap_dropped <= 1'b1;
                    end
                    if (hs) begin
`ifdef PROJ_DRAIN_CSUM_EN
                        csum_q <= csum_nxt;
`endif
                        if (at_end) begin
`ifdef PROJ_DRAIN_CSUM_EN
                            // Data done: present the XOR of all streamed beats.
                            out_idx  <= csum_nxt;
                            out_last <= 1'b1;
                            state_q  <= S_CSUM;
`else
                            out_idx   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_busy  <= 1'b0;
                            state_q   <= S_IDLE;
`endif
                        end else begin
                            ptr_q   <= ptr_nxt;
                            out_idx <= shadow_q[ptr_nxt];
`ifdef PROJ_DRAIN_CSUM_EN
                            out_last <= 1'b0;
`else
                            out_last <= nxt_last;
`endif
                        end
                    end
                end
`ifdef PROJ_DRAIN_CSUM_EN
                S_CSUM: begin
                    if (in_snap) begin
                        out_snap_dropped <= 1'b1;
                    end
                    if (hs) begin
                        out_idx   <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_busy  <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifndef PROJ_DRAIN_CSUM_EN
    // nxt_last only feeds the non-checksum build; keep the lint view tidy.
    logic unused_ok;
    assign unused_ok = nxt_last | 1'b0;
`else
    logic unused_ok;
    assign unused_ok = nxt_last;
`endif

endmodule

// File: tb/tb_proj_sketch_drain.sv
// tb_proj_sketch_drain: directed scoreboard bench for the sketch read-out block.
// Expected beats are queued at snapshot time and popped on each handshake.

module tb_proj_sketch_drain;

    localparam int IC = proj_pkg::HASHER_EXTENDER_INDICES_COUNT;
    localparam int L  = 8;
    localparam int CW = $clog2(IC + 1);
`ifdef PROJ_DRAIN_CSUM_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif

    typedef struct packed {
        logic [L-1:0] idx;
        logic         last;
    } beat_t;

    logic                  in_clk;
    logic                  in_rst;
    logic [IC-1:0][L-1:0]  in_smallest_idx;
    logic [CW-1:0]         in_fill_count;
    logic                  in_snap;
    logic [L-1:0]          out_idx;
    logic                  out_valid;
    logic                  in_ready;
    logic                  out_last;
    logic                  out_busy;
    logic                  out_empty;
    logic                  out_snap_dropped;

    beat_t q[$];
    int    tests = 0;
    int    fails = 0;

    proj_sketch_drain dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_smallest_idx  (in_smallest_idx),
        .in_fill_count    (in_fill_count),
        .in_snap          (in_snap),
        .out_idx          (out_idx),
        .out_valid        (out_valid),
        .in_ready         (in_ready),
        .out_last         (out_last),
        .out_busy         (out_busy),
        .out_empty        (out_empty),
        .out_snap_dropped (out_snap_dropped)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic push_stream(input logic [IC-1:0][L-1:0] v, input int n);
        logic [L-1:0] x;
        beat_t b;
        x = '0;
        for (int i = 0; i < n; i++) begin
            b.idx  = v[i];
            b.last = (XB == 0) && (i == n - 1);
            q.push_back(b);
            x = x ^ v[i];
        end
        if (XB != 0) begin
            b.idx  = x;
            b.last = 1'b1;
            q.push_back(b);
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while ((out_busy || q.size() != 0) && cycles < budget) begin
            tick();
            cycles++;
        end
        chk(tag, {31'd0, (out_busy || q.size() != 0)}, 32'd0);
    endtask

    // Scoreboard monitor: every valid beat must match the queue head.
    always @(negedge in_clk) begin
        if (!in_rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("beat_idx", {24'd0, out_idx}, {24'd0, q[0].idx});
                chk("beat_last", {31'd0, out_last}, {31'd0, q[0].last});
                if (in_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [IC-1:0][L-1:0] base;
        logic [IC-1:0][L-1:0] full;
        logic [IC-1:0][L-1:0] alt;
        logic                 pat [4];
        int                   cyc;
        int                   i;

        base = '0;
        base[0] = 8'h05;
        base[1] = 8'h11;
        base[2] = 8'h22;
        base[3] = 8'h3A;
        for (int k = 4; k < IC; k++) begin
            base[k] = 8'(8'h40 + k);
        end
        for (int k = 0; k < IC; k++) begin
            full[k] = 8'(8'h80 + 3 * k);
        end
        alt = '0;
        alt[0] = 8'h71;
        alt[1] = 8'h62;
        alt[2] = 8'h53;
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;

        in_rst = 1'b1;
        in_smallest_idx = base;
        in_fill_count = '0;
        in_snap = 1'b0;
        in_ready = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, out_busy}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_idx", {24'd0, out_idx}, 32'd0);
        chk("rst_empty", {31'd0, out_empty}, 32'd0);
        chk("rst_dropped", {31'd0, out_snap_dropped}, 32'd0);
        in_rst = 1'b0;
        tick();

        // Basic 4-beat stream at full rate.
        in_fill_count = CW'(4);
        push_stream(base, 4);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_busy", {31'd0, out_busy}, 32'd1);
        chk("t1_first", {24'd0, out_idx}, 32'h05);
        wait_done("t1_drain", 20, cyc);
        chk("t1_cycles", cyc, 4 + XB);
        chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Backpressure with ready pattern 1,0,0,1.
        push_stream(base, 4);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        i = 0;
        while ((out_busy || q.size() != 0) && i < 60) begin
            in_ready = pat[i % 4];
            tick();
            i++;
        end
        chk("t2_drain", {31'd0, (out_busy || q.size() != 0)}, 32'd0);
        in_ready = 1'b1;
        tick();

        // Empty snapshot.
        in_fill_count = '0;
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        chk("t3_empty", {31'd0, out_empty}, 32'd1);
        chk("t3_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t3_empty_clr", {31'd0, out_empty}, 32'd0);
        chk("t3_busy", {31'd0, out_busy}, 32'd0);

        // Overfull count clamps to IC beats.
        in_smallest_idx = full;
        in_fill_count = CW'(IC + 3);
        push_stream(full, IC);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        wait_done("t4_drain", IC + 10, cyc);
        chk("t4_cycles", cyc, IC + XB);
        tick();

        // Snap requests while busy are dropped.
        in_smallest_idx = base;
        in_fill_count = CW'(4);
        push_stream(base, 4);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        tick();
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        chk("t5_drop_mid", {31'd0, out_snap_dropped}, 32'd1);
        tick();
        chk("t5_drop_clr", {31'd0, out_snap_dropped}, 32'd0);
        if (XB != 0) begin
            tick();
        end
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        chk("t5_drop_final", {31'd0, out_snap_dropped}, 32'd1);
        chk("t5_valid_off", {31'd0, out_valid}, 32'd0);
        chk("t5_q_empty", q.size(), 32'd0);
        tick();
        chk("t5_no_restart", {31'd0, out_busy}, 32'd0);
        chk("t5_drop_clr2", {31'd0, out_snap_dropped}, 32'd0);

        // Input changes after capture have no effect.
        push_stream(base, 4);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        in_smallest_idx = '1;
        in_fill_count = CW'(1);
        wait_done("t6_drain", 20, cyc);
        chk("t6_cycles", cyc, 4 + XB);
        in_smallest_idx = base;
        in_fill_count = CW'(4);
        tick();

        // Asynchronous reset mid-stream, then a fresh stream.
        push_stream(base, 4);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        tick();
        tick();
        #2;
        in_rst = 1'b1;
        #1;
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_busy", {31'd0, out_busy}, 32'd0);
        chk("t7_rst_last", {31'd0, out_last}, 32'd0);
        chk("t7_rst_idx", {24'd0, out_idx}, 32'd0);
        q.delete();
        tick();
        in_rst = 1'b0;
        tick();
        chk("t7_idle", {31'd0, out_valid}, 32'd0);
        in_smallest_idx = alt;
        in_fill_count = CW'(3);
        push_stream(alt, 3);
        in_snap = 1'b1;
        tick();
        in_snap = 1'b0;
        chk("t7_first", {24'd0, out_idx}, 32'h71);
        wait_done("t7_drain", 20, cyc);
        chk("t7_cycles", cyc, 3 + XB);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
